// File: rtl/ram_port_if.sv
// ram_port_if: user-side RAM port between the record/playback controller
// (master) and the memory responder (slave).
interface ram_port_if #(
    parameter int DATA_W = 16
);
    logic [25:0]       address;
    logic [DATA_W-1:0] data_in;
    logic              write_enable;
    logic              read_request;
    logic              read_ack;
    logic              rdy;
    logic              rd_data_pres;
    logic [DATA_W-1:0] data_out;
    logic [25:0]       max_ram_address;
    logic              ledRAM;
    logic              addr_err;

    modport master (
        output address, data_in, write_enable, read_request, read_ack,
        input  rdy, rd_data_pres, data_out, max_ram_address, ledRAM, addr_err
    );

    modport slave (
        input  address, data_in, write_enable, read_request, read_ack,
        output rdy, rd_data_pres, data_out, max_ram_address, ledRAM, addr_err
    );
endinterface

// File: rtl/ram_port_responder.sv
// ram_port_responder: block-RAM stand-in for the DDR user port. Emulates
// calibration delay after reset, the read handshake with fixed latency and
// write-first collision behaviour, and flags out-of-range accesses.
// Optional feature: define RAM_RESP_REFRESH_EN to emulate periodic refresh
// (rdy drops for 4 cycles every REFRESH_PERIOD cycles).
module ram_port_responder #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 16,
    parameter int RD_LATENCY     = 3,
    parameter int INIT_CYCLES    = 16,
    parameter int REFRESH_PERIOD = 256
) (
    input  logic      clk,
    input  logic      reset,
    ram_port_if.slave bus
);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_PRES = 2'd3;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [1:0]        state;
    logic [INIT_W-1:0] init_cnt;
    logic [3:0]        lat_cnt;
    logic [25:0]       rd_addr_p0;
    logic              rdy_q;
    logic              pres_q;
    logic              err_q;
    logic [DATA_W-1:0] dout_q;

    logic              addr_in_range;
    logic              rd_in_range;
    logic              wr_accept;
    logic              rd_accept;
    logic              wr_hits_rd;
    logic [DATA_W-1:0] fetch_data;

`ifdef RAM_RESP_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_PERIOD);
    logic [REF_W-1:0] ref_cnt;
    logic [2:0]       ref_hold;
`else
    logic [31:0] unused_refresh_period;
    assign unused_refresh_period = REFRESH_PERIOD;
`endif

    assign addr_in_range = (bus.address[25:ADDR_W] == '0);
    assign rd_in_range   = (rd_addr_p0[25:ADDR_W] == '0);
    assign wr_accept     = (state != ST_INIT) && rdy_q && bus.write_enable;
    assign rd_accept     = (state == ST_IDLE) && rdy_q && bus.read_request;
    // A write landing on the fetch edge must be seen by that fetch.
    assign wr_hits_rd    = wr_accept && (bus.address == rd_addr_p0);

    // Fetch value: zero for out-of-range, write-first bypass on collision.
    always_comb begin
        fetch_data = '0;
        if (rd_in_range) begin
            fetch_data = wr_hits_rd ? bus.data_in : mem[rd_addr_p0[ADDR_W-1:0]];
        end
    end

    // Buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept && addr_in_range) begin
            mem[bus.address[ADDR_W-1:0]] <= bus.data_in;
        end
    end

    // Port state machine: calibration wait, read handshake, error flag, refresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= INIT_W'(INIT_CYCLES);
            lat_cnt  <= '0;
            rdy_q    <= 1'b0;
            pres_q   <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
`ifdef RAM_RESP_REFRESH_EN
            ref_cnt  <= '0;
            ref_hold <= '0;
`endif
        end else begin
            if ((wr_accept || rd_accept) && !addr_in_range) begin
                err_q <= 1'b1;
            end

            case (state)
                ST_INIT: begin
                    if (init_cnt <= INIT_W'(1)) begin
                        init_cnt <= '0;
                        rdy_q    <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        init_cnt <= init_cnt - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (rd_accept) begin
                        rd_addr_p0 <= bus.address;
                        lat_cnt    <= 4'(RD_LATENCY - 1);
                        state      <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Latency counter freezes while the port is not ready.
                    if (rdy_q) begin
                        if (lat_cnt == 4'd0) begin
                            dout_q <= fetch_data;
                            pres_q <= 1'b1;
                            state  <= ST_RD_PRES;
                        end else begin
                            lat_cnt <= lat_cnt - 1'b1;
                        end
                    end
                end
                ST_RD_PRES: begin
                    if (bus.read_ack) begin
                        pres_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase

`ifdef RAM_RESP_REFRESH_EN
            // Refresh counter runs freely once out of INIT so the period is exact.
            if (state != ST_INIT) begin
                if (ref_cnt == REF_W'(REFRESH_PERIOD - 1)) begin
                    ref_cnt  <= '0;
                    ref_hold <= 3'd4;
                    rdy_q    <= 1'b0;
                end else begin
                    ref_cnt <= ref_cnt + 1'b1;
                    if (ref_hold == 3'd1) begin
                        rdy_q <= 1'b1;
                    end
                    if (ref_hold != 3'd0) begin
                        ref_hold <= ref_hold - 1'b1;
                    end
                end
            end
`endif
        end
    end

    assign bus.rdy             = rdy_q;
    assign bus.ledRAM          = rdy_q;
    assign bus.rd_data_pres    = pres_q;
    assign bus.data_out        = dout_q;
    assign bus.addr_err        = err_q;
    assign bus.max_ram_address = 26'((1 << ADDR_W) - 1);
endmodule

// File: tb/tb_ram_port_responder.sv
// tb_ram_port_responder: directed and randomized checks of the RAM port
// responder (default build) against an array-based memory model.
module tb_ram_port_responder;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 16;
    localparam int RD_LATENCY  = 3;
    localparam int INIT_CYCLES = 16;
    localparam int DEPTH       = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ram_port_if #(.DATA_W(DATA_W)) bus();

    ram_port_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY),
        .INIT_CYCLES(INIT_CYCLES), .REFRESH_PERIOD(256)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic              model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [25:0] a);
        return (a < DEPTH) ? model_mem[a[ADDR_W-1:0]] : '0;
    endfunction

    task automatic do_write(input logic [25:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.address = a; bus.data_in = d; bus.write_enable = 1'b1;
        @(negedge clk);
        bus.write_enable = 1'b0;
        if (a < DEPTH) model_mem[a[ADDR_W-1:0]] = d;
        else           model_err = 1'b1;
    endtask

    // Counts edges (sampled #1 after each) until rd_data_pres is seen.
    task automatic wait_pres(output int lat);
        lat = 0;
        while (bus.rd_data_pres !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack_read(input int ack_delay, input logic [DATA_W-1:0] exp, input string tag);
        @(negedge clk);
        bus.read_request = 1'b0;
        for (int k = 0; k < ack_delay; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_pres"}, bus.rd_data_pres, 1'b1);
            check({tag, "_hold_data"}, bus.data_out, exp);
            @(negedge clk);
        end
        bus.read_ack = 1'b1;
        @(posedge clk); #1;
        check({tag, "_clr"}, bus.rd_data_pres, 1'b0);
        check({tag, "_keep"}, bus.data_out, exp);
        @(negedge clk);
        bus.read_ack = 1'b0;
    endtask

    task automatic do_read(input logic [25:0] a, input int ack_delay, input string tag);
        int lat;
        logic [DATA_W-1:0] exp;
        exp = model_read(a);
        if (a >= DEPTH) model_err = 1'b1;
        @(negedge clk);
        bus.address = a; bus.read_request = 1'b1;
        @(posedge clk); #1;
        wait_pres(lat);
        check({tag, "_lat"}, lat, RD_LATENCY);
        check({tag, "_data"}, bus.data_out, exp);
        check({tag, "_err"}, bus.addr_err, model_err);
        ack_read(ack_delay, exp, tag);
    endtask

    task automatic wait_rdy(output int edges, output int led_mism, output int pres_seen);
        edges = 0; led_mism = 0; pres_seen = 0;
        while (bus.rdy !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (bus.ledRAM !== bus.rdy) led_mism++;
            if (bus.rd_data_pres !== 1'b0) pres_seen++;
        end
    endtask

    initial begin
        int edges, mism, pres_seen, lat;
        logic [25:0] a;

        bus.address = '0; bus.data_in = '0;
        bus.write_enable = 1'b0; bus.read_request = 1'b0; bus.read_ack = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", bus.rdy, 1'b0);
        check("rst_led", bus.ledRAM, 1'b0);
        check("rst_pres", bus.rd_data_pres, 1'b0);
        check("rst_dout", bus.data_out, '0);
        check("rst_err", bus.addr_err, 1'b0);
        check("max_addr", bus.max_ram_address, 26'h3FF);

        // Start-up delay
        @(negedge clk); reset = 1'b0;
        wait_rdy(edges, mism, pres_seen);
        check("init_edges", edges, INIT_CYCLES);
        check("init_led", mism, 0);
        check("init_led_hi", bus.ledRAM, 1'b1);

        // Fill buffer so the model is fully defined
        for (int i = 0; i < DEPTH; i++) do_write(26'(i), 16'($urandom));
        check("fill_err", bus.addr_err, 1'b0);

        // Basic write/read
        do_write(26'd5, 16'hA5A5);
        do_read(26'd5, 0, "rd_a5");
        do_read(26'd5, 2, "rd_a5_slowack");

        // Randomized mix of in-range writes and reads
        for (int i = 0; i < 40; i++) begin
            a = 26'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 0) do_write(a, 16'($urandom));
            else                           do_read(a, $urandom_range(0, 2), "rand_rd");
        end

        // Held request through ack: next read accepted one cycle after ack
        @(negedge clk);
        bus.address = 26'd5; bus.read_request = 1'b1;
        @(posedge clk); #1;
        wait_pres(lat);
        check("held1_data", bus.data_out, model_read(26'd5));
        @(negedge clk);
        bus.read_ack = 1'b1; bus.address = 26'd9;
        @(posedge clk); #1;
        check("held_ack_clr", bus.rd_data_pres, 1'b0);
        @(negedge clk);
        bus.read_ack = 1'b0;
        wait_pres(lat);
        check("held2_lat", lat, RD_LATENCY + 1);
        check("held2_data", bus.data_out, model_read(26'd9));
        ack_read(0, model_read(26'd9), "held2");

        // Collision: write during RD_WAIT
        @(negedge clk);
        bus.address = 26'd7; bus.read_request = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        bus.write_enable = 1'b1; bus.data_in = 16'h1234;
        @(posedge clk); #1;
        model_mem[7] = 16'h1234;
        @(negedge clk);
        bus.write_enable = 1'b0;
        wait_pres(lat);
        check("coll_wait_lat", lat + 1, RD_LATENCY);
        check("coll_wait_data", bus.data_out, 16'h1234);
        ack_read(0, 16'h1234, "coll_wait");

        // Collision on the fetch edge itself (write-first)
        @(negedge clk);
        bus.address = 26'd7; bus.read_request = 1'b1;
        @(posedge clk); #1;
        repeat (RD_LATENCY - 1) @(posedge clk);
        @(negedge clk);
        bus.write_enable = 1'b1; bus.data_in = 16'hBEEF;
        @(posedge clk); #1;
        model_mem[7] = 16'hBEEF;
        check("coll_fetch_pres", bus.rd_data_pres, 1'b1);
        check("coll_fetch_data", bus.data_out, 16'hBEEF);
        @(negedge clk);
        bus.write_enable = 1'b0;
        ack_read(0, 16'hBEEF, "coll_fetch");
        do_read(26'd7, 0, "coll_after");

        // Out-of-range read, then sticky flag
        do_read(26'd1024, 0, "oor_rd");
        do_read(26'd5, 0, "sticky");

        // Reset during RD_WAIT aborts the read
        @(negedge clk);
        bus.address = 26'd9; bus.read_request = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1; bus.read_request = 1'b0;
        @(posedge clk); #1;
        model_err = 1'b0;
        check("abort_pres", bus.rd_data_pres, 1'b0);
        check("abort_rdy", bus.rdy, 1'b0);
        check("abort_err", bus.addr_err, model_err);
        check("abort_dout", bus.data_out, '0);
        @(negedge clk); reset = 1'b0;
        wait_rdy(edges, mism, pres_seen);
        check("abort_no_pres", pres_seen, 0);
        check("reinit_edges", edges, INIT_CYCLES);

        // Out-of-range write: flag set, buffer untouched, contents kept over reset
        do_write(26'd2000, 16'hDEAD);
        check("oor_wr_err", bus.addr_err, model_err);
        do_read(26'd976, 1, "oor_wr_alias");
        do_read(26'd5, 0, "persist");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
